// File: rtl/riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : riscv_dmem_responder
// Description : Data-memory bus responder owning a local word RAM, with
//               programmable wait states and misaligned / window faults.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_dmem_responder #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] BASE        = '0,
    parameter int unsigned     MEM_WORDS   = 1024,
    parameter int unsigned     WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dmem_req,
    input  logic [XLEN-1:0]   dmem_adr,
    input  logic [XLEN-1:0]   dmem_d,
    input  logic              dmem_we,
    input  logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_q,
    output logic              dmem_ack,
    output logic              dmem_misaligned,
    output logic              dmem_page_fault,
    output logic              busy
);

    localparam int unsigned c_AW        = $clog2(MEM_WORDS);
    localparam int unsigned c_NB        = XLEN / 8;
    localparam logic        c_NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_WAIT = 2'd1;
    localparam logic [1:0]  c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_cnt;
    logic [c_AW-1:0] r_idx;
    logic [XLEN-1:0] r_d;
    logic            r_we;
    logic [c_NB-1:0] r_be;
    logic            r_mis;
    logic            r_pf;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_mem [MEM_WORDS];

    logic [XLEN:0]   w_off_ext;
    logic [XLEN-1:0] w_off;
    logic            w_in_range;
    logic            w_be_legal;
    logic            w_fault;
    logic            w_accept;
    logic            w_wait_done;
    logic            w_commit;
    logic [c_AW-1:0] w_idx;
    logic [XLEN-1:0] w_d;
    logic            w_we;
    logic [c_NB-1:0] w_be;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_merged;
    logic            w_unused;

    // Extra top bit is the borrow: set when the address lies below BASE.
    assign w_off_ext  = {1'b0, dmem_adr} - {1'b0, BASE};
    assign w_off      = w_off_ext[XLEN-1:0];
    assign w_in_range = !w_off_ext[XLEN] && (w_off[XLEN-1:2+c_AW] == '0);
    assign w_unused   = &{1'b0, w_off[1:0]};

    always_comb begin
        w_be_legal = 1'b0;
        case (dmem_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_be_legal = 1'b1;
            default:                   w_be_legal = 1'b0;
        endcase
    end

    assign w_fault     = !w_be_legal || !w_in_range;
    assign w_accept    = dmem_req && ((r_state == c_IDLE) || (r_state == c_RESP));
    assign w_wait_done = (r_state == c_WAIT) && (r_cnt == 4'd0);
    assign w_commit    = (w_accept && !w_fault && c_NO_WAIT) || w_wait_done;

    // Zero-wait accesses use the live request; delayed ones use the capture.
    assign w_idx   = w_wait_done ? r_idx : w_off[2+c_AW-1:2];
    assign w_d     = w_wait_done ? r_d   : dmem_d;
    assign w_we    = w_wait_done ? r_we  : dmem_we;
    assign w_be    = w_wait_done ? r_be  : dmem_be;
    assign w_rdata = r_mem[w_idx];

    always_comb begin
        w_merged = w_rdata;
        for (int i = 0; i < c_NB; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_d[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_RESP: begin
                if (w_accept) begin
                    w_state_nxt = (w_fault || c_NO_WAIT) ? c_RESP : c_WAIT;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_RESP;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        dmem_ack        = 1'b0;
        dmem_misaligned = 1'b0;
        dmem_page_fault = 1'b0;
        busy            = 1'b0;
        case (r_state)
            c_WAIT: busy = 1'b1;
            c_RESP: begin
                dmem_ack        = 1'b1;
                dmem_misaligned = r_mis;
                dmem_page_fault = r_pf;
            end
            default: ;
        endcase
    end

    assign dmem_q = r_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= 4'd0;
            r_idx <= '0;
            r_d   <= '0;
            r_we  <= 1'b0;
            r_be  <= '0;
            r_mis <= 1'b0;
            r_pf  <= 1'b0;
            r_q   <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= w_off[2+c_AW-1:2];
                r_d   <= dmem_d;
                r_we  <= dmem_we;
                r_be  <= dmem_be;
                r_mis <= !w_be_legal;
                r_pf  <= !w_in_range;
                r_cnt <= c_WAIT_INIT;
                if (w_fault) begin
                    r_q <= '0;
                end
            end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_q <= w_we ? w_merged : w_rdata;
            end
        end
    end

    // RAM is not reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (rstn && w_commit && w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_responder.sv
`default_nettype none
// Testbench for riscv_dmem_responder: three instances (zero-wait at BASE 0,
// zero-wait at BASE 'h1000, three wait states) checked against a scoreboard.
module tb_riscv_dmem_responder;

    localparam int c_N  = 3;
    localparam int c_WS = 3;

    typedef struct {
        int          cyc;
        logic [31:0] q;
        logic        mis;
        logic        pf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req  [c_N];
    logic [31:0] adr  [c_N];
    logic [31:0] d    [c_N];
    logic        we   [c_N];
    logic [3:0]  be   [c_N];
    logic [31:0] q    [c_N];
    logic        ack  [c_N];
    logic        mis  [c_N];
    logic        pf   [c_N];
    logic        busy [c_N];

    exp_t sb [c_N][$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_responder #(.XLEN(32), .BASE(32'h0), .MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rstn(rstn), .dmem_req(req[0]), .dmem_adr(adr[0]), .dmem_d(d[0]),
        .dmem_we(we[0]), .dmem_be(be[0]), .dmem_q(q[0]), .dmem_ack(ack[0]),
        .dmem_misaligned(mis[0]), .dmem_page_fault(pf[0]), .busy(busy[0]));

    riscv_dmem_responder #(.XLEN(32), .BASE(32'h1000), .MEM_WORDS(1024), .WAIT_STATES(0)) u_win (
        .clk(clk), .rstn(rstn), .dmem_req(req[1]), .dmem_adr(adr[1]), .dmem_d(d[1]),
        .dmem_we(we[1]), .dmem_be(be[1]), .dmem_q(q[1]), .dmem_ack(ack[1]),
        .dmem_misaligned(mis[1]), .dmem_page_fault(pf[1]), .busy(busy[1]));

    riscv_dmem_responder #(.XLEN(32), .BASE(32'h0), .MEM_WORDS(1024), .WAIT_STATES(c_WS)) u_ws3 (
        .clk(clk), .rstn(rstn), .dmem_req(req[2]), .dmem_adr(adr[2]), .dmem_d(d[2]),
        .dmem_we(we[2]), .dmem_be(be[2]), .dmem_q(q[2]), .dmem_ack(ack[2]),
        .dmem_misaligned(mis[2]), .dmem_page_fault(pf[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%h, expected 'h%h", tag, obs, exp);
        end
    endtask

    // Every ack is matched against the oldest expectation for that instance.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < c_N; k++) begin
            if (ack[k]) begin
                check($sformatf("dut%0d_ack_expected", k), 32'(sb[k].size() != 0), 32'd1);
                if (sb[k].size() != 0) begin
                    e = sb[k].pop_front();
                    check($sformatf("dut%0d_ack_cycle", k), 32'(cyc), 32'(e.cyc));
                    check($sformatf("dut%0d_q", k), q[k], e.q);
                    check($sformatf("dut%0d_flags", k), {30'd0, mis[k], pf[k]}, {30'd0, e.mis, e.pf});
                end
            end else begin
                check($sformatf("dut%0d_flags_idle", k), {30'd0, mis[k], pf[k]}, 32'd0);
            end
        end
    end

    task automatic drive(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] dd, input logic [3:0] b);
        req[k] = 1'b1;
        we[k]  = w;
        adr[k] = a;
        d[k]   = dd;
        be[k]  = b;
    endtask

    // Called on a falling edge; returns one cycle later with the strobe dropped.
    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] dd, input logic [3:0] b,
                         input logic [31:0] eq, input logic em, input logic ep,
                         input int lat);
        exp_t e;
        e.cyc = cyc + 1 + lat;
        e.q   = eq;
        e.mis = em;
        e.pf  = ep;
        sb[k].push_back(e);
        drive(k, w, a, dd, b);
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    task automatic wait_ack(input int k);
        int n = 0;
        while (!ack[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_ack_timeout", k), 32'(ack[k]), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag, input int k);
        check({tag, "_q"}, q[k], 32'd0);
        check({tag, "_ctl"}, {28'd0, ack[k], mis[k], pf[k], busy[k]}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < c_N; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; d[k] = '0; be[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_N; k++) check_idle_outputs($sformatf("reset_dut%0d", k), k);
        rstn = 1'b1;
        @(negedge clk);

        // Read-after-write and lane merging at BASE 0, no wait states.
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0, 0, 0); wait_ack(0);
        issue(0, 0, 32'h10, 32'h0,        4'b1111, 32'hDEADBEEF, 0, 0, 0); wait_ack(0);
        issue(0, 1, 32'h12, 32'h00AA0000, 4'b0100, 32'hDEAABEEF, 0, 0, 0); wait_ack(0);
        issue(0, 0, 32'h10, 32'h0,        4'b1111, 32'hDEAABEEF, 0, 0, 0); wait_ack(0);
        issue(0, 1, 32'h14, 32'h0,        4'b1111, 32'h00000000, 0, 0, 0); wait_ack(0);
        issue(0, 1, 32'h14, 32'hAABB0000, 4'b1100, 32'hAABB0000, 0, 0, 0); wait_ack(0);
        issue(0, 1, 32'h14, 32'h0000CC00, 4'b0010, 32'hAABBCC00, 0, 0, 0); wait_ack(0);
        issue(0, 1, 32'h14, 32'h55000000, 4'b1000, 32'h55BBCC00, 0, 0, 0); wait_ack(0);
        issue(0, 1, 32'h14, 32'h00000077, 4'b0001, 32'h55BBCC77, 0, 0, 0); wait_ack(0);
        issue(0, 0, 32'h17, 32'h0,        4'b0011, 32'h55BBCC77, 0, 0, 0); wait_ack(0);

        // Illegal byte-enable patterns fault and leave the RAM untouched.
        issue(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0110, 32'h0,        1, 0, 0); wait_ack(0);
        issue(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0,        1, 0, 0); wait_ack(0);
        issue(0, 0, 32'h10, 32'h0,        4'b0101, 32'h0,        1, 0, 0); wait_ack(0);
        issue(0, 0, 32'h10, 32'h0,        4'b1111, 32'hDEAABEEF, 0, 0, 0); wait_ack(0);
        @(negedge clk);

        // Address window at BASE 'h1000 with 1024 words.
        issue(1, 1, 32'h1000,     32'h01020304, 4'b1111, 32'h01020304, 0, 0, 0); wait_ack(1);
        issue(1, 0, 32'h0FFC,     32'h0,        4'b1111, 32'h0,        0, 1, 0); wait_ack(1);
        issue(1, 0, 32'h2000,     32'h0,        4'b1111, 32'h0,        0, 1, 0); wait_ack(1);
        issue(1, 1, 32'h1FFC,     32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0, 0, 0); wait_ack(1);
        issue(1, 0, 32'h1FFC,     32'h0,        4'b1111, 32'hCAFEF00D, 0, 0, 0); wait_ack(1);
        issue(1, 0, 32'h2000,     32'h0,        4'b0101, 32'h0,        1, 1, 0); wait_ack(1);
        issue(1, 0, 32'hFFFFF000, 32'h0,        4'b1111, 32'h0,        0, 1, 0); wait_ack(1);
        issue(1, 0, 32'h1000,     32'h0,        4'b1111, 32'h01020304, 0, 0, 0); wait_ack(1);
        @(negedge clk);

        // Three wait states: busy window and an ignored request mid-wait.
        issue(2, 1, 32'h20, 32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5, 0, 0, c_WS); wait_ack(2);
        @(negedge clk);
        issue(2, 0, 32'h20, 32'h0, 4'b1111, 32'hA5A5A5A5, 0, 0, c_WS);
        check("ws3_busy_c1", {31'd0, busy[2]}, 32'd1);
        drive(2, 1, 32'h20, 32'h0, 4'b1111);
        check("ws3_busy_c2", {31'd0, busy[2]}, 32'd1);
        @(negedge clk);
        req[2] = 1'b0;
        check("ws3_busy_c3", {31'd0, busy[2]}, 32'd1);
        check("ws3_no_early_ack", {31'd0, ack[2]}, 32'd0);
        wait_ack(2);
        check("ws3_busy_ack", {31'd0, busy[2]}, 32'd0);
        repeat (6) @(negedge clk);

        // Back-to-back requests issued in the ack cycles.
        issue(2, 0, 32'h20, 32'h0, 4'b1111, 32'hA5A5A5A5, 0, 0, c_WS); wait_ack(2);
        issue(2, 0, 32'h20, 32'h0, 4'b1111, 32'hA5A5A5A5, 0, 0, c_WS); wait_ack(2);
        issue(2, 0, 32'h20, 32'h0, 4'b1111, 32'hA5A5A5A5, 0, 0, c_WS); wait_ack(2);
        issue(2, 0, 32'h20, 32'h0, 4'b0000, 32'h0,        1, 0, 0);
        check("ws3_fault_busy", {31'd0, busy[2]}, 32'd0);
        wait_ack(2);
        @(negedge clk);
        issue(2, 0, 32'h20, 32'h0, 4'b1111, 32'hA5A5A5A5, 0, 0, c_WS); wait_ack(2);
        @(negedge clk);

        // Reset during WAIT abandons the write; a request alongside reset is dropped.
        drive(2, 1, 32'h20, 32'h12345678, 4'b1111);
        @(negedge clk);
        req[2] = 1'b0;
        check("rst_mid_busy", {31'd0, busy[2]}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        drive(0, 1, 32'h10, 32'h0, 4'b1111);
        @(negedge clk);
        rstn = 1'b1;
        req[0] = 1'b0;
        check_idle_outputs("rst_mid_dut2", 2);
        check_idle_outputs("rst_mid_dut0", 0);
        repeat (2) @(negedge clk);
        issue(2, 0, 32'h20, 32'h0, 4'b1111, 32'hA5A5A5A5, 0, 0, c_WS); wait_ack(2);
        issue(0, 0, 32'h10, 32'h0, 4'b1111, 32'hDEAABEEF, 0, 0, 0);    wait_ack(0);
        repeat (8) @(negedge clk);

        for (int k = 0; k < c_N; k++) begin
            check($sformatf("dut%0d_scoreboard_empty", k), 32'(sb[k].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
